dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_pkg.sv | 8 +
 rtl/dmem_if.sv | 16 +
 rtl/dmem_array.sv | 17 +
 rtl/dmem_responder.sv | 76 +++++++
 tb/tb_dmem_responder.sv | 139 +++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared widths, FSM states and error-check constants for the data-memory responder.
package dmem_pkg;
  localparam int DEF_WORD = 32;
  localparam int DEF_DMEM_OFFSET = 1024;
  localparam int CNT_W = 4;
  localparam logic [1:0] ALIGN_OK = 2'b00;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
endpackage

// File: rtl/dmem_if.sv
// dmem_if: request/response handshake bundle between an initiator and the data-memory responder.
interface dmem_if #(parameter int WORD = 32);
  logic req_valid;
  logic req_ready;
  logic req_we;
  logic [WORD-1:0] req_addr;
  logic [WORD-1:0] req_wdata;
  logic rsp_valid;
  logic rsp_ready;
  logic rsp_err;
  logic [WORD-1:0] rsp_rdata;
  modport master(output req_valid, req_we, req_addr, req_wdata, rsp_ready,
                 input req_ready, rsp_valid, rsp_rdata, rsp_err);
  modport slave(input req_valid, req_we, req_addr, req_wdata, rsp_ready,
                output req_ready, rsp_valid, rsp_rdata, rsp_err);
endinterface

// File: rtl/dmem_array.sv
// dmem_array: DEPTH x WORD storage, synchronous write, combinational read, never reset.
module dmem_array #(
  parameter int WORD = 32,
  parameter int DEPTH = 256,
  parameter int AW = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            i_we,
  input  logic [AW-1:0]   i_addr,
  input  logic [WORD-1:0] i_wdata,
  output logic [WORD-1:0] o_rdata
);
  logic [WORD-1:0] r_mem [DEPTH];
  always_ff @(posedge clk)
    if (i_we) r_mem[i_addr] <= i_wdata;
  assign o_rdata = r_mem[i_addr];
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding memory responder with fixed request-to-response latency.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int WORD = DEF_WORD,
  parameter int DEPTH = 256,
  parameter int LATENCY = 3,
  parameter int DMEM_OFFSET = DEF_DMEM_OFFSET
) (
  input  logic  clk,
  input  logic  rst,
  dmem_if.slave io_bus
);
  localparam int AW = $clog2(DEPTH);
  state_t r_state;
  logic [CNT_W-1:0] r_cnt;
  logic r_we;
  logic [WORD-1:0] r_addr;
  logic [WORD-1:0] r_wdata;
  logic r_rsp_valid;
  logic r_rsp_err;
  logic [WORD-1:0] r_rsp_rdata;
  logic w_acc;
  logic w_exec;
  logic w_we;
  logic [WORD-1:0] w_addr;
  logic [WORD-1:0] w_wdata;
  logic [WORD-1:0] w_idx;
  logic w_err;
  logic [WORD-1:0] w_rdata;
  assign w_acc = io_bus.req_valid && r_state == IDLE;
  // With LATENCY==1 the access runs in the accept cycle itself, straight from the bus.
  assign w_exec = !rst && (r_state == BUSY ? r_cnt == CNT_W'(1) : (w_acc && LATENCY == 1));
  assign w_we = r_state == BUSY ? r_we : io_bus.req_we;
  assign w_addr = r_state == BUSY ? r_addr : io_bus.req_addr;
  assign w_wdata = r_state == BUSY ? r_wdata : io_bus.req_wdata;
  assign w_idx = (w_addr >> 2) - WORD'(DMEM_OFFSET);
  assign w_err = w_addr[1:0] != ALIGN_OK || w_idx >= WORD'(DEPTH);
  dmem_array #(.WORD(WORD), .DEPTH(DEPTH)) u_array (
    .clk(clk),
    .i_we(w_exec && w_we && !w_err),
    .i_addr(w_idx[AW-1:0]),
    .i_wdata(w_wdata),
    .o_rdata(w_rdata)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err <= 1'b0;
      r_rsp_rdata <= '0;
    end else if (w_exec) begin
      r_state <= RESP;
      r_cnt <= '0;
      r_rsp_valid <= 1'b1;
      r_rsp_err <= w_err;
      r_rsp_rdata <= (w_we || w_err) ? '0 : w_rdata;
    end else if (w_acc) begin
      r_state <= BUSY;
      r_cnt <= CNT_W'(LATENCY - 1);
      r_we <= io_bus.req_we;
      r_addr <= io_bus.req_addr;
      r_wdata <= io_bus.req_wdata;
    end else if (r_state == BUSY) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end else if (r_state == RESP && io_bus.rsp_ready) begin
      r_state <= IDLE;
      r_rsp_valid <= 1'b0;
    end
  end
  assign io_bus.req_ready = r_state == IDLE;
  assign io_bus.rsp_valid = r_rsp_valid;
  assign io_bus.rsp_err = r_rsp_err;
  assign io_bus.rsp_rdata = r_rsp_rdata;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed table plus hand sequences for stall, reset-in-BUSY and back-to-back.
module tb_dmem_responder;
  localparam int LAT = 3;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int cyc = 0;
  int errs = 0;
  int checks = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  dmem_if #(.WORD(32)) bus ();
  dmem_responder #(.WORD(32), .DEPTH(256), .LATENCY(LAT), .DMEM_OFFSET(1024)) dut (
    .clk(clk),
    .rst(rst),
    .io_bus(bus)
  );
  typedef struct {
    logic we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic err;
    logic [31:0] rdata;
  } vec_t;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  task automatic accept(input logic we, input logic [31:0] addr, input logic [31:0] wdata, output int acc);
    int n = 0;
    bus.req_valid = 1'b1;
    bus.req_we = we;
    bus.req_addr = addr;
    bus.req_wdata = wdata;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n == 20) begin
      errs++;
      $display("FAIL accept_timeout: got no req_ready want req_ready");
    end
    acc = cyc;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask
  task automatic await_rsp(output int at);
    int n = 0;
    while (!bus.rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n == 20) begin
      errs++;
      $display("FAIL rsp_timeout: got no rsp_valid want rsp_valid");
    end
    at = cyc;
  endtask
  task automatic xact(input vec_t v, input string nm);
    int acc, at;
    bus.rsp_ready = 1'b1;
    accept(v.we, v.addr, v.wdata, acc);
    await_rsp(at);
    chk({nm, "_lat"}, at - acc, LAT);
    chk({nm, "_err"}, {31'b0, bus.rsp_err}, {31'b0, v.err});
    chk({nm, "_rdata"}, bus.rsp_rdata, v.rdata);
    @(negedge clk);
  endtask
  vec_t tbl [12];
  initial begin
    int acc, at, a1, a2;
    tbl[0]  = '{1'b1, 32'h1004, 32'hDEADBEEF, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 32'h1004, 32'h0,        1'b0, 32'hDEADBEEF};
    tbl[2]  = '{1'b0, 32'h1002, 32'h0,        1'b1, 32'h0};
    tbl[3]  = '{1'b0, 32'h0FFC, 32'h0,        1'b1, 32'h0};
    tbl[4]  = '{1'b1, 32'h1000, 32'h11111111, 1'b0, 32'h0};
    tbl[5]  = '{1'b1, 32'h1400, 32'h55555555, 1'b1, 32'h0};
    tbl[6]  = '{1'b0, 32'h1000, 32'h0,        1'b0, 32'h11111111};
    tbl[7]  = '{1'b1, 32'h13FC, 32'hCAFEF00D, 1'b0, 32'h0};
    tbl[8]  = '{1'b1, 32'h0FFC, 32'h77777777, 1'b1, 32'h0};
    tbl[9]  = '{1'b0, 32'h13FC, 32'h0,        1'b0, 32'hCAFEF00D};
    tbl[10] = '{1'b1, 32'h1007, 32'h99999999, 1'b1, 32'h0};
    tbl[11] = '{1'b0, 32'h1004, 32'h0,        1'b0, 32'hDEADBEEF};
    bus.req_valid = 1'b0;
    bus.req_we = 1'b0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
    chk("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("rst_rsp_err", {31'b0, bus.rsp_err}, 32'd0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    for (int i = 0; i < 12; i++) xact(tbl[i], $sformatf("vec%0d", i));
    // Response held under back-pressure.
    bus.rsp_ready = 1'b0;
    accept(1'b0, 32'h1004, 32'h0, acc);
    await_rsp(at);
    chk("stall_lat", at - acc, LAT);
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", {31'b0, bus.rsp_valid}, 32'd1);
      chk("stall_rdata", bus.rsp_rdata, 32'hDEADBEEF);
      chk("stall_err", {31'b0, bus.rsp_err}, 32'd0);
      chk("stall_req_ready", {31'b0, bus.req_ready}, 32'd0);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("stall_done_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("stall_done_req_ready", {31'b0, bus.req_ready}, 32'd1);
    // Reset in the second BUSY cycle drops the pending write.
    xact('{1'b1, 32'h1008, 32'h00000005, 1'b0, 32'h0}, "pre_rst_wr");
    accept(1'b1, 32'h1008, 32'h00001234, acc);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("busy_rst_valid", {31'b0, bus.rsp_valid}, 32'd0);
    chk("busy_rst_req_ready", {31'b0, bus.req_ready}, 32'd1);
    xact('{1'b0, 32'h1008, 32'h0, 1'b0, 32'h00000005}, "post_rst_rd");
    // Back-to-back: read request held valid while the write is in flight.
    bus.rsp_ready = 1'b1;
    accept(1'b1, 32'h10FC, 32'hA5A5A5A5, a1);
    accept(1'b0, 32'h10FC, 32'h0, a2);
    chk("b2b_gap", a2 - a1, LAT + 1);
    await_rsp(at);
    chk("b2b_lat", at - a2, LAT);
    chk("b2b_rdata", bus.rsp_rdata, 32'hA5A5A5A5);
    chk("b2b_err", {31'b0, bus.rsp_err}, 32'd0);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
